// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: PC command encodings and sequencer state shared by the PC and its users.
package pc_seq_pkg;
   localparam logic [1:0] PS_HOLD = 2'b00;
   localparam logic [1:0] PS_INC  = 2'b01;
   localparam logic [1:0] PS_LOAD = 2'b10;
   localparam logic [1:0] PS_OFFS = 2'b11;
   localparam int TMR_W = 8;
   typedef enum logic [2:0] {S_BOOT, S_FETCH, S_DECODE, S_UPDATE, S_HALT, S_FAULT} state_e;
endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: fetch handshake, decoder flags and PC command bundle of the sequencer.
interface pc_sequencer_if;
   logic        imem_req;
   logic        imem_ack;
   logic        ir_load;
   logic        stall;
   logic        is_branch;
   logic        cond_true;
   logic        is_jump;
   logic        is_halt;
   logic [31:0] offset;
   logic [31:0] target;
   logic [1:0]  ps;
   logic [31:0] pc_in;
   logic        halted;
   logic        fault;
   logic [31:0] retired;
   modport master (
      output imem_req, ir_load, ps, pc_in, halted, fault, retired,
      input  imem_ack, stall, is_branch, cond_true, is_jump, is_halt, offset, target
   );
   modport slave (
      input  imem_req, ir_load, ps, pc_in, halted, fault, retired,
      output imem_ack, stall, is_branch, cond_true, is_jump, is_halt, offset, target
   );
endinterface

// File: rtl/pc_sequencer_fetch_timer.sv
// fetch_timer: clearable saturating counter of ack-less fetch cycles; expired_o marks the last allowed one.
module fetch_timer
   import pc_seq_pkg::*;
#(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);
   localparam logic [TMR_W-1:0] LAST = TMR_W'(TIMEOUT - 1);
   logic [TMR_W-1:0] cnt_q, cnt_d;
   assign expired_o = cnt_q == LAST;
   assign cnt_d = clr_i ? '0 : (en_i && !expired_o) ? cnt_q + TMR_W'(1) : cnt_q;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch/decode/update FSM issuing exactly one PC command per instruction,
// with halt, fetch-timeout and misaligned-jump faults and a retired-instruction counter.
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter int unsigned TIMEOUT = 16
) (
   input logic clk,
   input logic rst_n,
   pc_sequencer_if.master bus
);
   state_e      state_q;
   logic [1:0]  ps_q, ps_d;
   logic [31:0] pc_in_q, pc_in_d;
   logic        imem_req_q, halted_q, fault_q;
   logic [31:0] retired_q;
   logic        expired, taken, misaligned;
   fetch_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr_i     (state_q != S_FETCH),
      .en_i      (state_q == S_FETCH && !bus.imem_ack),
      .expired_o (expired)
   );
   always_comb begin
      taken      = bus.is_branch && bus.cond_true;
      misaligned = bus.is_jump && |bus.target[1:0];
      ps_d       = bus.is_jump ? PS_LOAD : taken ? PS_OFFS : PS_INC;
      pc_in_d    = bus.is_jump ? bus.target : taken ? bus.offset : '0;
   end
   // Command outputs default to hold every cycle so they live for the UPDATE cycle only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_BOOT;
         ps_q       <= PS_HOLD;
         pc_in_q    <= '0;
         imem_req_q <= 1'b0;
         halted_q   <= 1'b0;
         fault_q    <= 1'b0;
         retired_q  <= '0;
      end else begin
         ps_q       <= PS_HOLD;
         pc_in_q    <= '0;
         imem_req_q <= 1'b0;
         case (state_q)
            S_BOOT: begin
               state_q    <= S_FETCH;
               imem_req_q <= 1'b1;
            end
            S_FETCH:
               if (bus.imem_ack) state_q <= S_DECODE;
               else if (expired) begin
                  state_q <= S_FAULT;
                  fault_q <= 1'b1;
               end else imem_req_q <= 1'b1;
            S_DECODE:
               if (!bus.stall) begin
                  if (bus.is_halt) begin
                     state_q  <= S_HALT;
                     halted_q <= 1'b1;
                  end else if (misaligned) begin
                     state_q <= S_FAULT;
                     fault_q <= 1'b1;
                  end else begin
                     state_q <= S_UPDATE;
                     ps_q    <= ps_d;
                     pc_in_q <= pc_in_d;
                  end
               end
            S_UPDATE: begin
               state_q    <= S_FETCH;
               imem_req_q <= 1'b1;
               retired_q  <= retired_q + 32'd1;
            end
            default: state_q <= state_q;
         endcase
      end
   end
   assign bus.imem_req = imem_req_q;
   assign bus.ir_load  = state_q == S_FETCH && bus.imem_ack;
   assign bus.ps       = ps_q;
   assign bus.pc_in    = pc_in_q;
   assign bus.halted   = halted_q;
   assign bus.fault    = fault_q;
   assign bus.retired  = retired_q;
endmodule
